// File: rtl/cpu_controller.sv
// cpu_controller: single-cycle 19-bit instruction decoder and control unit
module cpu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] allBits,
  input  logic        Zero,
  input  logic        CarryOut,
  output logic [1:0]  selectToWrite,
  output logic        selectR2,
  output logic        selectAluArg,
  output logic [2:0]  ALUfunction,
  output logic [1:0]  sh_roFunction,
  output logic        STM,
  output logic        LDM,
  output logic        enablePC,
  output logic        enableZero,
  output logic        enableCarry,
  output logic        memRead,
  output logic [1:0]  selectAdress,
  output logic        push,
  output logic        pop,
  output logic        RET
);
  logic       armed_q, armed_d, live, taken, unused_bits;
  logic [4:0] op;
  assign op = allBits[18:14];
  assign unused_bits = ^allBits[13:0];
  assign live = armed_q & ~rst;
  assign taken = op[1] ? (CarryOut ^ op[0]) : (Zero ^ op[0]);
  assign armed_d = 1'b1;
  always_ff @(posedge clk)
    if (rst) armed_q <= 1'b0;
    else armed_q <= armed_d;
  always_comb begin
    selectToWrite = 2'b00;
    selectR2 = 1'b0;
    selectAluArg = 1'b0;
    ALUfunction = 3'b000;
    sh_roFunction = 2'b00;
    STM = 1'b0;
    LDM = 1'b0;
    enablePC = live;
    enableZero = 1'b0;
    enableCarry = 1'b0;
    memRead = 1'b0;
    selectAdress = 2'b00;
    push = 1'b0;
    pop = 1'b0;
    RET = 1'b0;
    if (live)
      casez (op)
        5'b0????: begin
          selectToWrite = 2'b01;
          selectAluArg = op[3];
          ALUfunction = op[2:0];
          enableZero = 1'b1;
          enableCarry = 1'b1;
        end
        5'b110??: begin
          selectToWrite = 2'b10;
          sh_roFunction = op[1:0];
          enableZero = 1'b1;
        end
        5'b10000: begin
          LDM = 1'b1;
          memRead = 1'b1;
          selectAluArg = 1'b1;
          selectToWrite = 2'b11;
        end
        5'b10001: begin
          STM = 1'b1;
          selectR2 = 1'b1;
          selectAluArg = 1'b1;
        end
        5'b101??: selectAdress = {1'b0, taken};
        5'b11100: selectAdress = 2'b10;
        5'b11101: begin
          selectAdress = 2'b10;
          push = 1'b1;
        end
        5'b11110: begin
          selectAdress = 2'b11;
          pop = 1'b1;
          RET = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed checks of cpu_controller decode and reset squash
module tb_cpu_controller;
  logic        clk = 1'b0, rst = 1'b1, Zero = 1'b0, CarryOut = 1'b0;
  logic [18:0] allBits = 19'b0;
  logic [1:0]  selectToWrite, sh_roFunction, selectAdress;
  logic [2:0]  ALUfunction;
  logic        selectR2, selectAluArg, STM, LDM, enablePC, enableZero, enableCarry, memRead, push, pop, RET;
  logic [19:0] obs;
  int          checks = 0, errors = 0;
  cpu_controller dut (
    .clk(clk), .rst(rst), .allBits(allBits), .Zero(Zero), .CarryOut(CarryOut),
    .selectToWrite(selectToWrite), .selectR2(selectR2), .selectAluArg(selectAluArg),
    .ALUfunction(ALUfunction), .sh_roFunction(sh_roFunction), .STM(STM), .LDM(LDM),
    .enablePC(enablePC), .enableZero(enableZero), .enableCarry(enableCarry),
    .memRead(memRead), .selectAdress(selectAdress), .push(push), .pop(pop), .RET(RET)
  );
  always #5 clk = ~clk;
  assign obs = {selectToWrite, selectR2, selectAluArg, ALUfunction, sh_roFunction, STM, LDM,
                enablePC, enableZero, enableCarry, memRead, selectAdress, push, pop, RET};
  function automatic logic [19:0] e(input logic [1:0] sw, input logic r2, input logic aa,
                                    input logic [2:0] alu, input logic [1:0] sh, input logic stm,
                                    input logic ldm, input logic ez, input logic ec, input logic mr,
                                    input logic [1:0] sa, input logic pu, input logic po, input logic rt);
    return {sw, r2, aa, alu, sh, stm, ldm, 1'b1, ez, ec, mr, sa, pu, po, rt};
  endfunction
  task automatic chk(input string tag, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [18:0] ins, input logic z, input logic c, input logic [19:0] exp);
    @(negedge clk);
    allBits = ins;
    Zero = z;
    CarryOut = c;
    #1 chk(tag, exp);
  endtask
  initial begin
    allBits = 19'b0000010010101100000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset_held", 20'd0);
    rst = 1'b0;
    #1 chk("first_cycle_squash", 20'd0);
    step("alu_r", 19'b0000010010101100000, 0, 0, e(2'b01,0,0,3'b000,2'b00,0,0,1,1,0,2'b00,0,0,0));
    step("alu_imm", 19'b0111111110000010000, 0, 0, e(2'b01,0,1,3'b111,2'b00,0,0,1,1,0,2'b00,0,0,0));
    step("alu_r_sub", 19'b0001100000000000000, 1, 1, e(2'b01,0,0,3'b011,2'b00,0,0,1,1,0,2'b00,0,0,0));
    step("shift", 19'b1101100110001000000, 0, 0, e(2'b10,0,0,3'b000,2'b11,0,0,1,0,0,2'b00,0,0,0));
    step("shift_01", 19'b1100100000000000000, 0, 0, e(2'b10,0,0,3'b000,2'b01,0,0,1,0,0,2'b00,0,0,0));
    step("ldm", 19'b1000010010100010000, 0, 0, e(2'b11,0,1,3'b000,2'b00,0,1,0,0,1,2'b00,0,0,0));
    step("stm", 19'b1000110010100010000, 0, 0, e(2'b00,1,1,3'b000,2'b00,1,0,0,0,0,2'b00,0,0,0));
    step("bz_nt", 19'b1010011111100010000, 0, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    Zero = 1'b1;
    #1 chk("bz_t_comb", e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b01,0,0,0));
    step("bnz_t", 19'b1010100000000000000, 0, 1, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b01,0,0,0));
    step("bnz_nt", 19'b1010100000000000000, 1, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    step("bc_t", 19'b1011000000000000000, 0, 1, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b01,0,0,0));
    step("bc_nt", 19'b1011000000000000000, 1, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    step("bnc_t", 19'b1011100000000001000, 0, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b01,0,0,0));
    step("bnc_nt", 19'b1011100000000001000, 0, 1, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    step("jmp", 19'b1110011000100000000, 0, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b10,0,0,0));
    step("jsb", 19'b1110100100000000000, 0, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b10,1,0,0));
    step("ret", 19'b1111000000000000000, 0, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b11,0,1,1));
    step("nop_11111", 19'b1111100000000000000, 1, 1, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    step("nop_10010", 19'b1001000000000000000, 1, 1, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    step("nop_10011", 19'b1001100000000000000, 1, 1, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b00,0,0,0));
    @(negedge clk);
    allBits = 19'b1110100100000000000;
    rst = 1'b1;
    #1 chk("mid_reset_comb", 20'd0);
    @(negedge clk);
    #1 chk("mid_reset_held", 20'd0);
    rst = 1'b0;
    #1 chk("post_mid_reset_squash", 20'd0);
    step("post_mid_reset_jsb", 19'b1110100100000000000, 0, 0, e(2'b00,0,0,3'b000,2'b00,0,0,0,0,0,2'b10,1,0,0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
